// File: rtl/dct_postfft_twid.sv
// Post-FFT twiddle stage of an FFT-based DCT-II: D1(k) = F(k) * exp(-j*pi*k/(2N)), 4-stage stallable pipeline.
// Optional macro DCT_POSTFFT_SAT_EN: clamp out-of-range results instead of two's-complement wrap.
module dct_postfft_twid #(
  parameter int wDataInOut = 16,
  parameter int wTw        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic [1:0]            sink_error,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic [wDataInOut-1:0] sink_real,
  input  logic [wDataInOut-1:0] sink_imag,
  input  logic [11:0]           fftpts_in,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [1:0]            source_error,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic [wDataInOut-1:0] source_real,
  output logic [wDataInOut-1:0] source_imag,
  output logic [11:0]           fftpts_out
);
  localparam int WP = wDataInOut + wTw;
  localparam int WF = WP + 1;
  localparam int FS = 2**(wTw-1) - 1;
  localparam logic signed [WF-1:0] RND  = WF'(2**(wTw-2));
  localparam logic signed [WF-1:0] MAXV = WF'(2**(wDataInOut-1) - 1);
  localparam logic signed [WF-1:0] MINV = ~MAXV;

  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  err;
    logic [11:0] pts;
  } side_t;

  // Quarter-wave twiddle tables, evaluated at elaboration.
  function automatic logic signed [wTw-1:0] twid(input int m, input logic want_sin);
    real x, v;
    int  r;
    x = 3.14159265358979323846 * real'(m) / 4096.0;
    v = want_sin ? $sin(x) : $cos(x);
    r = $rtoi(v * real'(FS) + 0.5);
    return r[wTw-1:0];
  endfunction

  function automatic logic [wDataInOut-1:0] reduce(input logic signed [WF-1:0] x);
    logic signed [WF-1:0] r;
    r = (x + RND) >>> (wTw - 1);
`ifdef DCT_POSTFFT_SAT_EN
    if (r > MAXV) r = MAXV;
    else if (r < MINV) r = MINV;
`endif
    return wDataInOut'(r);
  endfunction

  logic signed [wTw-1:0] cos_rom [0:2047];
  logic signed [wTw-1:0] sin_rom [0:2047];

  genvar g;
  generate
    for (g = 0; g < 2048; g++) begin : g_rom
      assign cos_rom[g] = twid(g, 1'b0);
      assign sin_rom[g] = twid(g, 1'b1);
    end
  endgenerate

  // Handshake: a beat moves on a clock edge where valid & ready; every stage advances only when en.
  logic en, accept, take;
  assign en         = source_ready | ~source_valid;
  assign sink_ready = en;
  assign accept     = sink_valid & en;

  // Frame size decode; an unsupported size runs as 2048 and flags every beat.
  logic        n_ok;
  logic [3:0]  new_shift;
  logic [10:0] new_last;
  always_comb begin
    n_ok      = $onehot(fftpts_in) && (fftpts_in[2:0] == 3'd0);
    new_shift = 4'd0;
    new_last  = 11'h7ff;
    if (n_ok) begin
      new_last = 11'(fftpts_in - 12'd1);
      for (int i = 3; i < 12; i++)
        if (fftpts_in[i]) new_shift = 4'(11 - i);
    end
  end

  state_t      state;
  logic [10:0] k_q, n_last_q, idx, cur_last;
  logic [3:0]  n_shift_q, cur_shift;
  logic        n_bad_q, cur_bad;
  logic [11:0] n_pts_q, cur_pts;
  logic [1:0]  beat_err;

  assign take      = accept & (sink_sop | (state == RUN));
  assign cur_last  = sink_sop ? new_last  : n_last_q;
  assign cur_shift = sink_sop ? new_shift : n_shift_q;
  assign cur_bad   = sink_sop ? ~n_ok     : n_bad_q;
  assign cur_pts   = sink_sop ? fftpts_in : n_pts_q;
  assign idx       = sink_sop ? 11'd0     : k_q;
  assign beat_err  = sink_error | {1'b0, cur_bad | (sink_eop & (idx != cur_last))};

  logic                         s1_valid, s2_valid, s3_valid;
  side_t                        s1_side, s2_side, s3_side;
  logic signed [wDataInOut-1:0] s1_a, s1_b, s2_a, s2_b;
  logic [10:0]                  s1_k, rom_addr;
  logic [3:0]                   s1_shift;
  logic signed [wTw-1:0]        s2_cos, s2_sin;
  logic signed [WP-1:0]         s3_ac, s3_bs, s3_bc, s3_as;
  logic signed [WF-1:0]         re_full, im_full;

  assign rom_addr = s1_k << s1_shift;
  assign re_full  = WF'(s3_ac) + WF'(s3_bs);
  assign im_full  = WF'(s3_bc) - WF'(s3_as);

  // Stage 1 plus framing FSM: register the beat and its bin index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      n_last_q  <= '0;
      n_shift_q <= '0;
      n_bad_q   <= 1'b0;
      n_pts_q   <= '0;
      s1_valid  <= 1'b0;
      s1_side   <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_k      <= '0;
      s1_shift  <= '0;
    end else if (en) begin
      s1_valid <= take;
      s1_side  <= {sink_sop, sink_eop, beat_err, cur_pts};
      s1_a     <= $signed(sink_real);
      s1_b     <= $signed(sink_imag);
      s1_k     <= idx;
      s1_shift <= cur_shift;
      if (take) begin
        k_q   <= (idx == cur_last) ? 11'd0 : idx + 11'd1;
        state <= sink_eop ? IDLE : RUN;
        if (sink_sop) begin
          n_last_q  <= new_last;
          n_shift_q <= new_shift;
          n_bad_q   <= ~n_ok;
          n_pts_q   <= fftpts_in;
        end
      end
    end
  end

  // Stages 2-4: ROM read, four products, combine/round/reduce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      s2_side      <= '0;
      s2_a         <= '0;
      s2_b         <= '0;
      s2_cos       <= '0;
      s2_sin       <= '0;
      s3_valid     <= 1'b0;
      s3_side      <= '0;
      s3_ac        <= '0;
      s3_bs        <= '0;
      s3_bc        <= '0;
      s3_as        <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= 2'b00;
      source_real  <= '0;
      source_imag  <= '0;
      fftpts_out   <= '0;
    end else if (en) begin
      s2_valid     <= s1_valid;
      s2_side      <= s1_side;
      s2_a         <= s1_a;
      s2_b         <= s1_b;
      s2_cos       <= cos_rom[rom_addr];
      s2_sin       <= sin_rom[rom_addr];
      s3_valid     <= s2_valid;
      s3_side      <= s2_side;
      s3_ac        <= s2_a * s2_cos;
      s3_bs        <= s2_b * s2_sin;
      s3_bc        <= s2_b * s2_cos;
      s3_as        <= s2_a * s2_sin;
      source_valid <= s3_valid;
      source_sop   <= s3_side.sop;
      source_eop   <= s3_side.eop;
      source_error <= s3_side.err;
      source_real  <= reduce(re_full);
      source_imag  <= reduce(im_full);
      fftpts_out   <= s3_side.pts;
    end
  end
endmodule
